// File: rtl/run_step_controller.sv
// Execution sequencer: issues one-cycle cpu_en per instruction in free-run, single-step, break and halt modes.
// cpu_en is registered (one cycle after the tick/press that grants it); button press is accepted after sync + debounce.
module run_step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIV         = 50000000,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              run_mode,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  output logic              cpu_en,
  output logic [2:0]        state,
  output logic [31:0]       instr_count,
  output logic              halted
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_BREAK  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_lvl_q, db_lvl_d;
  logic             press;
  logic [DIV_W-1:0] div_q, div_d;
  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic [31:0]      count_q, count_d;
  logic             skip_bp_q, skip_bp_d;
  logic             tick;
  logic             try_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      db_lvl_q  <= 1'b0;
      div_q     <= '0;
      state_q   <= S_IDLE;
      cpu_en_q  <= 1'b0;
      count_q   <= '0;
      skip_bp_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      db_lvl_q  <= db_lvl_d;
      div_q     <= div_d;
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      count_q   <= count_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  // Counter tracks how long the synchronised level has disagreed with the accepted level.
  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    press    = 1'b0;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_lvl_d = sync2_q;
        press    = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    state_d   = state_q;
    cpu_en_d  = 1'b0;
    count_d   = count_q;
    skip_bp_d = skip_bp_q;
    div_d     = '0;
    try_issue = 1'b0;
    case (state_q)
      S_IDLE:   if (press) state_d = run_mode ? S_RUN : S_STEP;
      S_RUN: begin
        if (!run_mode) begin
          state_d = S_STEP;
        end else begin
          div_d     = tick ? '0 : div_q + 1'b1;
          try_issue = tick;
        end
      end
      S_STEP: begin
        if (press) begin
          if (run_mode) state_d = S_RUN;
          else          try_issue = 1'b1;
        end
      end
      S_BREAK: begin
        if (press) begin
          state_d   = run_mode ? S_RUN : S_STEP;
          skip_bp_d = 1'b1;
        end
      end
      S_HALTED: ;
      default:  state_d = S_IDLE;
    endcase

    // halt outranks the breakpoint; skip_bp lets the resumed instruction at bp_addr through once.
    if (try_issue) begin
      if (halt) begin
        state_d = S_HALTED;
      end else if (bp_valid && (pc == bp_addr) && !skip_bp_q) begin
        state_d = S_BREAK;
      end else begin
        cpu_en_d  = 1'b1;
        count_d   = count_q + 32'd1;
        skip_bp_d = 1'b0;
      end
    end
  end

  always_comb begin
    cpu_en      = cpu_en_q;
    state       = state_q;
    instr_count = count_q;
    halted      = (state_q == S_HALTED);
  end

endmodule

// File: tb/tb_run_step_controller.sv
// Bench for run_step_controller: directed scenarios plus random stimulus against a cycle-level reference model.
module tb_run_step_controller;

  localparam int DB  = 4;
  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button = 1'b0;
  logic        run_mode = 1'b0;
  logic        halt = 1'b0;
  logic        bp_valid = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] bp_addr = 32'd0;
  logic        cpu_en;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  run_step_controller #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (DIV),
    .ADDR_W         (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .run_mode   (run_mode),
    .halt       (halt),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .cpu_en     (cpu_en),
    .state      (state),
    .instr_count(instr_count),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference model: button samples two edges old, a stable-run length, cycles spent in RUN.
  bit          m_hist[2];
  bit          m_db;
  int          m_run;
  int          m_mode;
  int          m_runcyc;
  bit          m_skip;
  bit          m_en;
  logic [31:0] m_count;
  bit          auto_pc = 1'b0;
  bit          seen_bp_issue = 1'b0;

  task automatic model_step();
    bit s;
    bit press;
    bit try_issue;
    press     = 1'b0;
    try_issue = 1'b0;
    m_en      = 1'b0;
    if (rst) begin
      m_hist[0] = 1'b0; m_hist[1] = 1'b0;
      m_db = 1'b0; m_run = 0; m_mode = 0; m_runcyc = 0;
      m_skip = 1'b0; m_count = 32'd0;
      return;
    end
    s = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = button;
    if (s != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = s;
        m_run = 0;
        press = s;
      end
    end else begin
      m_run = 0;
    end

    case (m_mode)
      0: if (press) begin
        m_mode = run_mode ? 1 : 2;
        m_runcyc = 0;
      end
      1: begin
        if (!run_mode) m_mode = 2;
        else begin
          try_issue = ((m_runcyc % DIV) == DIV - 1);
          m_runcyc++;
        end
      end
      2: if (press) begin
        if (run_mode) begin m_mode = 1; m_runcyc = 0; end
        else try_issue = 1'b1;
      end
      3: if (press) begin
        m_mode = run_mode ? 1 : 2;
        m_runcyc = 0;
        m_skip = 1'b1;
      end
      default: ;
    endcase

    if (try_issue) begin
      if (halt) m_mode = 4;
      else if (bp_valid && pc == bp_addr && !m_skip) m_mode = 3;
      else begin
        m_en = 1'b1;
        m_count = m_count + 32'd1;
        m_skip = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("state", 32'(state), 32'(m_mode));
    chk("cpu_en", 32'(cpu_en), 32'(m_en));
    chk("instr_count", instr_count, m_count);
    chk("halted", 32'(halted), 32'(m_mode == 4));
    if (cpu_en && pc == 32'h0C) seen_bp_issue = 1'b1;
    if (auto_pc && m_en) pc = (pc >= 32'h10) ? 32'd0 : pc + 32'd4;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_btn();
    button = 1'b1; idle(8);
    button = 1'b0; idle(8);
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    idle(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;

    // Bouncing press lands in STEP without issuing
    run_mode = 1'b0; bp_valid = 1'b1; bp_addr = 32'h0C; pc = 32'h100;
    button = 1'b1; cyc(); button = 1'b0; cyc();
    button = 1'b1; cyc(); button = 1'b0; cyc();
    button = 1'b1; idle(10);
    button = 1'b0; idle(8);
    chk("bounce_state", 32'(state), 32'd2);
    chk("bounce_count", instr_count, 32'd0);

    // Three clean single steps away from the breakpoint
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'($urandom_range(0, 63)) * 4;
      press_btn();
    end
    chk("step3_count", instr_count, 32'd3);
    chk("step3_state", 32'(state), 32'd2);

    // Free-run into the breakpoint, resume through it, loop back into it
    rst = 1'b1; idle(2); rst = 1'b0;
    run_mode = 1'b1; pc = 32'd0; auto_pc = 1'b1;
    press_btn();
    idle(20);
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_count", instr_count, 32'd3);
    seen_bp_issue = 1'b0;
    press_btn();
    idle(30);
    chk("bp_resume_issue", 32'(seen_bp_issue), 32'd1);
    chk("bp_loop_state", 32'(state), 32'd3);
    chk("bp_loop_count", instr_count, 32'd8);

    // halt and breakpoint at the same issue point: halt wins, presses ignored
    rst = 1'b1; idle(2); rst = 1'b0;
    auto_pc = 1'b0; run_mode = 1'b0; pc = 32'h0C; bp_addr = 32'h0C; bp_valid = 1'b0;
    press_btn();
    press_btn();
    halt = 1'b1; bp_valid = 1'b1;
    press_btn();
    chk("halt_state", 32'(state), 32'd4);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", instr_count, 32'd1);
    press_btn();
    chk("halt_sticky", 32'(state), 32'd4);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_count", instr_count, 32'd0);

    // Reset mid-RUN and mid-debounce
    halt = 1'b0; bp_valid = 1'b0; run_mode = 1'b1; pc = 32'd0; auto_pc = 1'b1;
    press_btn();
    idle(10);
    button = 1'b1; idle(3);
    rst = 1'b1; button = 1'b0; cyc();
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrst_count", instr_count, 32'd0);
    rst = 1'b0;
    idle(12);
    chk("post_rst_count", instr_count, 32'd0);
    chk("post_rst_state", 32'(state), 32'd0);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) button = ~button;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
      halt = ($urandom_range(0, 149) == 0);
      bp_valid = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(0, 4)) * 4;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
